// File: rtl/tile_scan_generator.sv
// tile_scan_generator
//   Generates 640x480@60 VGA scan timing from a 25 MHz pixel clock and, for each
//   pixel, works out which graphics source the memory controller should fetch:
//   a playfield tile (28x31 tiles of 8x8 at ORIGIN_X/ORIGIN_Y), a single 8x8
//   sprite (drawn on top, also over the border), or nothing outside active video.
//
//   Pipeline, for the pixel whose counters are (h,v) in cycle n:
//     n+1  o_map_addr (map RAM address)
//     n+2  i_map_data returned by the map RAM, sampled at the end of this cycle
//     n+3  o_mem_select, o_address_map, o_tile_offset, o_address_char, o_char_offset
//     n+4  o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N (lines up with the controller's RGB)
//
// Ports
//   i_clk, i_rst           pixel clock, asynchronous active-high reset
//   i_char_x/y/frame       sprite position and frame; latched once per frame
//   o_map_addr, i_map_data map RAM read port (1-cycle read latency)
//   o_mem_select           00 none, 01 tile, 11 sprite
//   o_address_map          tile index, o_tile_offset pixel within tile {dy,dx}
//   o_address_char         sprite frame, o_char_offset pixel within sprite {dy,dx}
//   o_VGA_HS/VS            active-low syncs, o_VGA_BLANK_N high in active video
//   o_frame_start          one-cycle pulse while counters are at (0,0)
module tile_scan_generator #(
    parameter int unsigned ORIGIN_X = 208,
    parameter int unsigned ORIGIN_Y = 116
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [9:0] i_char_x,
    input  logic [9:0] i_char_y,
    input  logic [7:0] i_char_frame,
    output logic [9:0] o_map_addr,
    input  logic [7:0] i_map_data,
    output logic [1:0] o_mem_select,
    output logic [7:0] o_address_map,
    output logic [5:0] o_tile_offset,
    output logic [7:0] o_address_char,
    output logic [5:0] o_char_offset,
    output logic       o_VGA_HS,
    output logic       o_VGA_VS,
    output logic       o_VGA_BLANK_N,
    output logic       o_frame_start
);

    localparam logic [9:0] H_LAST   = 10'd799;
    localparam logic [9:0] V_LAST   = 10'd524;
    localparam logic [9:0] H_ACTIVE = 10'd640;
    localparam logic [9:0] V_ACTIVE = 10'd480;
    localparam logic [9:0] HS_FIRST = 10'd656;
    localparam logic [9:0] HS_LAST  = 10'd751;
    localparam logic [9:0] VS_FIRST = 10'd490;
    localparam logic [9:0] VS_LAST  = 10'd491;

    // Playfield window, 11 bits so ORIGIN + size never wraps
    localparam logic [10:0] PF_X0 = 11'(ORIGIN_X);
    localparam logic [10:0] PF_X1 = 11'(ORIGIN_X + 224);
    localparam logic [10:0] PF_Y0 = 11'(ORIGIN_Y);
    localparam logic [10:0] PF_Y1 = 11'(ORIGIN_Y + 248);

    // ------------------------------------------------------------------
    // Scan counters
    // ------------------------------------------------------------------
    logic [9:0] h_q, v_q;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            h_q <= '0;
            v_q <= '0;
        end else if (h_q == H_LAST) begin
            h_q <= '0;
            v_q <= (v_q == V_LAST) ? 10'd0 : v_q + 10'd1;
        end else begin
            h_q <= h_q + 10'd1;
        end
    end

    // Not delayed: the pulse marks the counter position, and is held low in reset.
    assign o_frame_start = !i_rst && (h_q == 10'd0) && (v_q == 10'd0);

    // ------------------------------------------------------------------
    // Sprite shadow registers: loaded only at the start of vertical blank so
    // a sprite never changes position or frame partway down the screen.
    // 1023 puts the box below every visible line until the first load.
    // ------------------------------------------------------------------
    logic [9:0] cx_q, cy_q;
    logic [7:0] frame_q;
    logic       shadow_load;

    assign shadow_load = (h_q == 10'd0) && (v_q == V_ACTIVE);

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            cx_q    <= 10'h3FF;
            cy_q    <= 10'h3FF;
            frame_q <= '0;
        end else if (shadow_load) begin
            cx_q    <= i_char_x;
            cy_q    <= i_char_y;
            frame_q <= i_char_frame;
        end
    end

    // ------------------------------------------------------------------
    // Stage 0: decode the current counter position
    // ------------------------------------------------------------------
    logic [10:0] h_ext, v_ext, cx_ext, cy_ext;
    logic        active0, in_pf0, spr_hit0, hs0, vs0;
    logic [7:0]  pf_dx, pf_dy;
    logic [2:0]  spr_dx, spr_dy;
    logic [9:0]  map_addr0;
    logic [5:0]  tile_off0, char_off0;
    logic [7:0]  char_frame0;

    assign h_ext  = {1'b0, h_q};
    assign v_ext  = {1'b0, v_q};
    assign cx_ext = {1'b0, cx_q};
    assign cy_ext = {1'b0, cy_q};

    assign active0 = (h_q < H_ACTIVE) && (v_q < V_ACTIVE);
    assign in_pf0  = active0 && (h_ext >= PF_X0) && (h_ext < PF_X1)
                     && (v_ext >= PF_Y0) && (v_ext < PF_Y1);

    assign pf_dx     = 8'(h_ext - PF_X0);
    assign pf_dy     = 8'(v_ext - PF_Y0);
    assign map_addr0 = in_pf0 ? (({5'b0, pf_dy[7:3]} * 10'd28) + {5'b0, pf_dx[7:3]}) : 10'd0;
    assign tile_off0 = in_pf0 ? {pf_dy[2:0], pf_dx[2:0]} : 6'd0;

    // Sprite box is only clipped by active video, not by the playfield
    assign spr_hit0    = active0 && (h_ext >= cx_ext) && (h_ext < cx_ext + 11'd8)
                         && (v_ext >= cy_ext) && (v_ext < cy_ext + 11'd8);
    assign spr_dx      = 3'(h_ext - cx_ext);
    assign spr_dy      = 3'(v_ext - cy_ext);
    assign char_off0   = spr_hit0 ? {spr_dy, spr_dx} : 6'd0;
    assign char_frame0 = spr_hit0 ? frame_q : 8'd0;

    assign hs0 = !((h_q >= HS_FIRST) && (h_q <= HS_LAST));
    assign vs0 = !((v_q >= VS_FIRST) && (v_q <= VS_LAST));

    // ------------------------------------------------------------------
    // Pipeline stages 1..4
    // ------------------------------------------------------------------
    logic       s1_in_pf, s1_spr_hit, s1_active, s1_hs, s1_vs;
    logic [5:0] s1_tile_off, s1_char_off;
    logic [7:0] s1_char_frame;
    logic       s2_in_pf, s2_spr_hit, s2_active, s2_hs, s2_vs;
    logic [5:0] s2_tile_off, s2_char_off;
    logic [7:0] s2_char_frame;
    logic       s3_active, s3_hs, s3_vs;

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            o_map_addr     <= '0;
            s1_in_pf       <= 1'b0;
            s1_spr_hit     <= 1'b0;
            s1_active      <= 1'b0;
            s1_hs          <= 1'b1;
            s1_vs          <= 1'b1;
            s1_tile_off    <= '0;
            s1_char_off    <= '0;
            s1_char_frame  <= '0;
            s2_in_pf       <= 1'b0;
            s2_spr_hit     <= 1'b0;
            s2_active      <= 1'b0;
            s2_hs          <= 1'b1;
            s2_vs          <= 1'b1;
            s2_tile_off    <= '0;
            s2_char_off    <= '0;
            s2_char_frame  <= '0;
            o_mem_select   <= 2'b00;
            o_address_map  <= '0;
            o_tile_offset  <= '0;
            o_address_char <= '0;
            o_char_offset  <= '0;
            s3_active      <= 1'b0;
            s3_hs          <= 1'b1;
            s3_vs          <= 1'b1;
            o_VGA_HS       <= 1'b1;
            o_VGA_VS       <= 1'b1;
            o_VGA_BLANK_N  <= 1'b0;
        end else begin
            // Stage 1: map address goes out to the RAM
            o_map_addr    <= map_addr0;
            s1_in_pf      <= in_pf0;
            s1_spr_hit    <= spr_hit0;
            s1_active     <= active0;
            s1_hs         <= hs0;
            s1_vs         <= vs0;
            s1_tile_off   <= tile_off0;
            s1_char_off   <= char_off0;
            s1_char_frame <= char_frame0;

            // Stage 2: waiting on the RAM read
            s2_in_pf      <= s1_in_pf;
            s2_spr_hit    <= s1_spr_hit;
            s2_active     <= s1_active;
            s2_hs         <= s1_hs;
            s2_vs         <= s1_vs;
            s2_tile_off   <= s1_tile_off;
            s2_char_off   <= s1_char_off;
            s2_char_frame <= s1_char_frame;

            // Stage 3: memory controller request, tile data now available
            if (s2_spr_hit) begin
                o_mem_select <= 2'b11;
            end else if (s2_in_pf) begin
                o_mem_select <= 2'b01;
            end else begin
                o_mem_select <= 2'b00;
            end
            o_address_map  <= s2_in_pf ? i_map_data : 8'd0;
            o_tile_offset  <= s2_tile_off;
            o_address_char <= s2_char_frame;
            o_char_offset  <= s2_char_off;
            s3_active      <= s2_active;
            s3_hs          <= s2_hs;
            s3_vs          <= s2_vs;

            // Stage 4: syncs delayed to match the controller's tileset RAM
            o_VGA_HS      <= s3_hs;
            o_VGA_VS      <= s3_vs;
            o_VGA_BLANK_N <= s3_active;
        end
    end

endmodule

// File: tb/tb_tile_scan_generator.sv
// Scoreboard bench for tile_scan_generator. Cycle 0 is the first cycle after
// reset release (counters at 0,0); pixel (h,v) of frame f is counter cycle
// f*420000 + v*800 + h. Expected values are hand-computed and queued by cycle;
// a monitor pops and compares them on the falling edge.
module tb_tile_scan_generator;

    localparam int S_MAP   = 0;
    localparam int S_SEL   = 1;
    localparam int S_AMAP  = 2;
    localparam int S_TOFF  = 3;
    localparam int S_ACHAR = 4;
    localparam int S_COFF  = 5;
    localparam int S_HS    = 6;
    localparam int S_VS    = 7;
    localparam int S_BLANK = 8;
    localparam int S_FS    = 9;

    localparam int FRAME = 420000;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [9:0] i_char_x, i_char_y;
    logic [7:0] i_char_frame;
    logic [9:0] o_map_addr;
    logic [7:0] i_map_data = 8'd0;
    logic [1:0] o_mem_select;
    logic [7:0] o_address_map, o_address_char;
    logic [5:0] o_tile_offset, o_char_offset;
    logic       o_VGA_HS, o_VGA_VS, o_VGA_BLANK_N, o_frame_start;

    tile_scan_generator #(
        .ORIGIN_X(208),
        .ORIGIN_Y(116)
    ) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_char_x      (i_char_x),
        .i_char_y      (i_char_y),
        .i_char_frame  (i_char_frame),
        .o_map_addr    (o_map_addr),
        .i_map_data    (i_map_data),
        .o_mem_select  (o_mem_select),
        .o_address_map (o_address_map),
        .o_tile_offset (o_tile_offset),
        .o_address_char(o_address_char),
        .o_char_offset (o_char_offset),
        .o_VGA_HS      (o_VGA_HS),
        .o_VGA_VS      (o_VGA_VS),
        .o_VGA_BLANK_N (o_VGA_BLANK_N),
        .o_frame_start (o_frame_start)
    );

    always #5 i_clk = ~i_clk;

    // Map RAM model: one-cycle read, contents = addr*7+5 (so address 0 holds 0x05)
    always @(posedge i_clk) i_map_data <= 8'(int'(o_map_addr) * 7 + 5);

    int cyc;
    always @(posedge i_clk or posedge i_rst) begin
        if (i_rst) cyc <= 0;
        else       cyc <= cyc + 1;
    end

    typedef struct {
        int due;
        int sig;
        int exp_v;
    } exp_t;

    exp_t sb[$];
    int   checks = 0;
    int   errors = 0;

    function automatic string sig_name(int s);
        case (s)
            S_MAP:   return "map_addr";
            S_SEL:   return "mem_select";
            S_AMAP:  return "address_map";
            S_TOFF:  return "tile_offset";
            S_ACHAR: return "address_char";
            S_COFF:  return "char_offset";
            S_HS:    return "VGA_HS";
            S_VS:    return "VGA_VS";
            S_BLANK: return "VGA_BLANK_N";
            S_FS:    return "frame_start";
            default: return "unknown";
        endcase
    endfunction

    function automatic int dut_sig(int s);
        case (s)
            S_MAP:   return int'(o_map_addr);
            S_SEL:   return int'(o_mem_select);
            S_AMAP:  return int'(o_address_map);
            S_TOFF:  return int'(o_tile_offset);
            S_ACHAR: return int'(o_address_char);
            S_COFF:  return int'(o_char_offset);
            S_HS:    return int'(o_VGA_HS);
            S_VS:    return int'(o_VGA_VS);
            S_BLANK: return int'(o_VGA_BLANK_N);
            S_FS:    return int'(o_frame_start);
            default: return -1;
        endcase
    endfunction

    function automatic void check(string tag, int s, int exp_v);
        int act;
        act = dut_sig(s);
        checks++;
        if (act != exp_v) begin
            errors++;
            $display("FAIL %s %s: got %0d expected %0d (t=%0t)", tag, sig_name(s), act,
                     exp_v, $time);
        end
    endfunction

    // Insert keeping the queue ordered by due cycle
    function automatic void push(int due, int s, int exp_v);
        exp_t e;
        int   pos;
        e.due   = due;
        e.sig   = s;
        e.exp_v = exp_v;
        pos     = sb.size();
        while (pos > 0 && sb[pos-1].due > due) pos--;
        sb.insert(pos, e);
    endfunction

    // Queue every pipeline output for one pixel at counter cycle n
    function automatic void expect_px(int n, int map, int sel, int amap, int toff,
                                      int achar, int coff, int blank);
        push(n + 1, S_MAP, map);
        push(n + 3, S_SEL, sel);
        push(n + 3, S_AMAP, amap);
        push(n + 3, S_TOFF, toff);
        push(n + 3, S_ACHAR, achar);
        push(n + 3, S_COFF, coff);
        push(n + 4, S_BLANK, blank);
    endfunction

    function automatic int px(int frame, int h, int v);
        return frame * FRAME + v * 800 + h;
    endfunction

    // Monitor
    always @(negedge i_clk) begin
        if (!i_rst) begin
            while (sb.size() > 0 && sb[0].due <= cyc) begin
                exp_t e;
                e = sb.pop_front();
                if (e.due < cyc) begin
                    checks++;
                    errors++;
                    $display("FAIL sb %s: cycle %0d not sampled, now %0d", sig_name(e.sig),
                             e.due, cyc);
                end else begin
                    check($sformatf("cyc%0d", e.due), e.sig, e.exp_v);
                end
            end
        end
    end

    function automatic void check_reset_outputs(string tag);
        check(tag, S_MAP, 0);
        check(tag, S_SEL, 0);
        check(tag, S_AMAP, 0);
        check(tag, S_TOFF, 0);
        check(tag, S_ACHAR, 0);
        check(tag, S_COFF, 0);
        check(tag, S_HS, 1);
        check(tag, S_VS, 1);
        check(tag, S_BLANK, 0);
        check(tag, S_FS, 0);
    endfunction

    task automatic wait_cyc(int target);
        while (cyc < target) @(negedge i_clk);
    endtask

    task automatic drain(int budget);
        int start;
        start = cyc;
        while (sb.size() > 0 && cyc - start < budget) @(negedge i_clk);
        if (sb.size() > 0) begin
            checks++;
            errors++;
            $display("FAIL drain: %0d expectations left, 0 required", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #15_000_000;
        $display("FAIL watchdog: simulation time exhausted at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        i_char_x     = 10'd300;
        i_char_y     = 10'd200;
        i_char_frame = 8'h12;

        repeat (3) @(posedge i_clk);
        #1;
        check_reset_outputs("in_reset");

        // Frame 0: timing
        push(0, S_FS, 1);
        push(1, S_FS, 0);
        push(419999, S_FS, 0);
        push(FRAME, S_FS, 1);
        push(2 * FRAME, S_FS, 1);
        push(659, S_HS, 1);
        push(660, S_HS, 0);
        push(755, S_HS, 0);
        push(756, S_HS, 1);
        push(1460, S_HS, 0);
        push(392003, S_VS, 1);
        push(392004, S_VS, 0);
        push(393603, S_VS, 0);
        push(393604, S_VS, 1);

        // Frame 0: playfield, borders, blanking; sprite not latched yet
        //        n                   map  sel amap toff achar coff blank
        expect_px(px(0, 208, 116),      0, 1,   5,   0,  0,   0,  1);
        expect_px(px(0, 207, 116),      0, 0,   0,   0,  0,   0,  1);
        expect_px(px(0, 215, 123),      0, 1,   5,  63,  0,   0,  1);
        expect_px(px(0, 300, 150),    123, 1,  98,  20,  0,   0,  1);
        expect_px(px(0, 303, 205),    319, 1, 190,  15,  0,   0,  1);
        expect_px(px(0, 431, 363),    867, 1, 186,  63,  0,   0,  1);
        expect_px(px(0, 432, 363),      0, 0,   0,   0,  0,   0,  1);
        expect_px(px(0, 639, 100),      0, 0,   0,   0,  0,   0,  1);
        expect_px(px(0, 640, 100),      0, 0,   0,   0,  0,   0,  0);

        // Frame 1: sprite latched at (300,200) frame 0x12
        expect_px(px(1, 300, 200),    291, 3, 250,  36, 18,   0,  1);
        expect_px(px(1, 303, 205),    319, 3, 190,  15, 18,  43,  1);
        expect_px(px(1, 307, 207),    320, 3, 197,  27, 18,  63,  1);
        expect_px(px(1, 308, 205),    320, 1, 197,  12,  0,   0,  1);
        expect_px(px(1, 299, 205),    319, 1, 190,  11,  0,   0,  1);
        expect_px(px(1, 303, 208),    319, 1, 190,  39,  0,   0,  1);
        expect_px(px(1, 103, 205),      0, 0,   0,   0,  0,   0,  1);

        // Frame 2: sprite moved to x=100
        expect_px(px(2, 103, 205),      0, 3,   0,   0, 18,  43,  1);
        expect_px(px(2, 303, 205),    319, 1, 190,  15,  0,   0,  1);

        @(posedge i_clk);
        #2 i_rst = 1'b0;

        // Move the sprite mid-frame 1; it must not take effect until frame 2
        wait_cyc(px(1, 0, 100));
        i_char_x = 10'd100;

        // Asynchronous reset mid-line at (500,300) of frame 2
        wait_cyc(px(2, 500, 300));
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL pre_reset: %0d expectations left, 0 required", sb.size());
            sb.delete();
        end
        check("pre_reset", S_BLANK, 1);
        i_rst = 1'b1;
        #1;
        check_reset_outputs("async_reset");
        @(posedge i_clk);
        #1;
        check_reset_outputs("held_reset");
        #1 i_rst = 1'b0;

        // After release the frame restarts from (0,0)
        push(0, S_FS, 1);
        push(1, S_FS, 0);
        push(643, S_BLANK, 1);
        push(644, S_BLANK, 0);
        push(659, S_HS, 1);
        push(660, S_HS, 0);
        expect_px(px(0, 5, 0), 0, 0, 0, 0, 0, 0, 1);

        drain(2000);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/tile_scan_generator.md
TILE_SCAN_GENERATOR -- requirements
Module: tile_scan_generator

Interface
REQ-001 Single clock i_clk, the 25 MHz pixel clock; reset i_rst, asynchronous, active-high.
REQ-002 Parameters (name, default, meaning): ORIGIN_X, 208, first playfield column in pixels; ORIGIN_Y, 116, first playfield line in pixels.
REQ-003 Ports (name direction width meaning):
- i_clk in 1 pixel clock
- i_rst in 1 async active-high reset
- i_char_x in 10 sprite left edge, pixels
- i_char_y in 10 sprite top edge, pixels
- i_char_frame in 8 sprite frame index
- o_map_addr out 10 map RAM read address
- i_map_data in 8 map RAM read data, valid one cycle after o_map_addr
- o_mem_select out 2 00 none, 01 tile, 11 sprite
- o_address_map out 8 tile index to memory controller
- o_tile_offset out 6 pixel within tile
- o_address_char out 8 sprite frame to memory controller
- o_char_offset out 6 pixel within sprite
- o_VGA_HS out 1 hsync, active low
- o_VGA_VS out 1 vsync, active low
- o_VGA_BLANK_N out 1 high in active video
- o_frame_start out 1 one-cycle pulse

Function
REQ-004 h counter 0..799, wraps to 0; v counter 0..524, increments on h wrap, wraps to 0.
REQ-005 Counter timing: active 640x480; h FP 16, sync 96 (h 656..751), BP 48; v FP 10, sync 2 (v 490..491), BP 33.
REQ-006 Pipeline depth: counter pixel (h,v) at cycle n; o_map_addr registered, valid n+1; i_map_data sampled at n+2; o_mem_select, o_address_map, o_tile_offset, o_address_char, o_char_offset registered, valid n+3; o_VGA_HS/VS/BLANK_N valid n+4, aligned with controller RGB after its 1-cycle tileset RAM.
REQ-007 Playfield: 28x31 tiles of 8x8 pixels, h in [ORIGIN_X, ORIGIN_X+224), v in [ORIGIN_Y, ORIGIN_Y+248).
REQ-008 Within playfield: col=(h-ORIGIN_X)>>3, row=(v-ORIGIN_Y)>>3, o_map_addr=row*28+col (0..867), o_tile_offset={dy[2:0],dx[2:0]}, o_address_map=i_map_data, select 01.
REQ-009 Outside playfield: o_map_addr=0, o_address_map=0, o_tile_offset=0.
REQ-010 Sprite box: h in [cx, cx+8), v in [cy, cy+8) using latched shadow cx/cy; 11-bit compare, no wrap at 1023.
REQ-011 Inside sprite box and active video: select 11 (priority over tile), o_address_char=shadow frame, o_char_offset={(v-cy)[2:0],(h-cx)[2:0]}; else o_address_char=0, o_char_offset=0.
REQ-012 Outside active video (h>=640 or v>=480): select 00, all address/offset outputs 0.
REQ-013 Shadow cx, cy, frame load from inputs only on the cycle counters are h=0, v=480; inputs ignored otherwise; frame never tears.
REQ-014 o_frame_start high for exactly the cycle counters are h=0, v=0 (counter domain, not delayed).
REQ-015 Sprite partially off-screen or off-playfield is clipped by REQ-012 only; sprite shown over border.

Reset
REQ-016 i_rst asserted: immediately h=0, v=0, all pipeline stages cleared; o_VGA_HS=1, o_VGA_VS=1, o_VGA_BLANK_N=0, o_mem_select=00, all address/offset outputs 0, o_frame_start=0.
REQ-017 Shadow cx=cy=1023, frame=0 on reset; no sprite drawn until first latch.
REQ-018 First cycle after deassert has counters at h=0, v=0 and o_frame_start=1; reset mid-frame restarts frame, no partial-line state retained.

Verification
REQ-019 Release reset -> o_frame_start on first cycle and every 420000 cycles; HS low 96 cycles per 800, first fall 660 cycles after frame_start; VS low 1600 cycles per frame.
REQ-020 Counter (208,116) -> o_map_addr=0 at n+1; drive i_map_data=0x05 at n+2 -> n+3 select 01, o_address_map=0x05, o_tile_offset=0; (215,123) -> offset 63; (431,363) -> o_map_addr=867.
REQ-021 i_char_x=300, i_char_y=200, i_char_frame=0x12 held over latch; pixel (303,205) -> select 11, o_char_offset=43, o_address_char=0x12; pixel (308,205) -> select 01.
REQ-022 Change i_char_x to 100 at v=300 -> current frame still draws at x=300; next frame at x=100.
REQ-023 Pixel (640,100) -> select 00, addresses 0 at n+3, BLANK_N=0 at n+4; pixel (639,100) -> BLANK_N=1 at n+4.
REQ-024 Assert i_rst at h=500, v=300 -> outputs take reset values same cycle without clock; after release counters resume at (0,0), frame_start pulses.
